// File: rtl/nvram_pkg.sv
// Shared definitions for the NVRAM store/recall block: FSM state encoding
// and the store-duration clamp.
package nvram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECALL = 2'd1,
        ST_STORE  = 2'd2
    } state_t;

    // A STORE must last long enough for the full pipelined copy plus the
    // cycle that drains the last word, so short requests are stretched.
    function automatic int unsigned store_len(input int unsigned cycles,
                                              input int unsigned addr_w);
        int unsigned min_len;
        min_len = (32'd1 << addr_w) + 32'd2;
        return (cycles < min_len) ? min_len : cycles;
    endfunction

endpackage

// File: rtl/dpram_sync.sv
// True dual-port synchronous RAM: each port can write, and each has a
// read register that updates only when its enable is high.
module dpram_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    // Read registers are cleared by reset; the array itself never is.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (en_a) q_a <= mem[addr_a];
            if (en_b) q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/nvram_store_recall.sv
// Volatile working array plus non-volatile shadow array with X2212-style
// block STORE/RECALL and a host port for loading/saving the shadow.
module nvram_store_recall
    import nvram_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 8,
    parameter int STORE_CYCLES    = 2000,
    parameter bit RECALL_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    input  logic              store,
    input  logic              recall,
    output logic              busy,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout
);

    localparam int unsigned DEPTH     = 2**ADDR_W;
    localparam int unsigned STORE_LEN = store_len(STORE_CYCLES, ADDR_W);
    localparam int          TIMER_W   = $clog2(STORE_LEN);
    localparam logic [ADDR_W:0]    CNT_LAST   = (ADDR_W+1)'(DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STORE_LEN - 1);

    state_t             state;
    logic [ADDR_W:0]    cnt;
    logic [TIMER_W-1:0] timer;

    logic              idle, in_recall, in_store;
    logic              copy_rd, copy_wr;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] work_q_b, shadow_q_b;

    assign idle      = (state == ST_IDLE);
    assign in_recall = (state == ST_RECALL);
    assign in_store  = (state == ST_STORE);

    // Copy pipeline: cycle k reads word k, cycle k+1 writes word k.
    assign copy_rd = ~cnt[ADDR_W];
    assign copy_wr = (cnt != '0);
    assign rd_addr = cnt[ADDR_W-1:0];
    assign wr_addr = ADDR_W'(cnt - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RECALL_ON_RESET ? ST_RECALL : ST_IDLE;
            busy  <= RECALL_ON_RESET;
            cnt   <= '0;
            timer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    timer <= '0;
                    if (recall) begin
                        state <= ST_RECALL;
                        busy  <= 1'b1;
                    end else if (store) begin
                        state <= ST_STORE;
                        busy  <= 1'b1;
                    end
                end
                ST_RECALL: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STORE: begin
                    // cnt parks at the last index while the timer runs out.
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    if (timer == TIMER_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    dpram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_work (
        .clk    (clk),
        .rst    (rst),
        .en_a   (idle & ~we),
        .we_a   (idle & we),
        .addr_a (addr),
        .din_a  (din),
        .q_a    (dout),
        .en_b   (in_store & copy_rd),
        .we_b   (in_recall & copy_wr),
        .addr_b (in_store ? rd_addr : wr_addr),
        .din_b  (shadow_q_b),
        .q_b    (work_q_b)
    );

    // Port A serves host reads at all times; port B is shared between host
    // writes (idle only) and the copy engine.
    dpram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .en_a   (1'b1),
        .we_a   (1'b0),
        .addr_a (host_addr),
        .din_a  ('0),
        .q_a    (host_dout),
        .en_b   (in_recall & copy_rd),
        .we_b   (idle ? host_we : (in_store & copy_wr)),
        .addr_b (idle ? host_addr : (in_recall ? rd_addr : wr_addr)),
        .din_b  (idle ? host_din : work_q_b),
        .q_b    (shadow_q_b)
    );

endmodule

// File: tb/tb_nvram_store_recall.sv
// Randomised self-checking bench: two instances (recall-on-reset with a
// 1000-cycle store, and no recall-on-reset with a clamped store length).
module tb_nvram_store_recall;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2], we[2], store[2], recall[2], host_we[2], busy[2];
    logic [7:0] addr[2], din[2], dout[2], host_addr[2], host_din[2], host_dout[2];

    int checks = 0;
    int errors = 0;

    // Reference contents of both arrays for each unit.
    logic [7:0] work_m[2][256];
    logic [7:0] shad_m[2][256];

    nvram_store_recall #(.DATA_W(8), .ADDR_W(8), .STORE_CYCLES(1000), .RECALL_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst[0]), .we(we[0]), .addr(addr[0]), .din(din[0]), .dout(dout[0]),
        .store(store[0]), .recall(recall[0]), .busy(busy[0]),
        .host_addr(host_addr[0]), .host_we(host_we[0]), .host_din(host_din[0]), .host_dout(host_dout[0])
    );

    nvram_store_recall #(.DATA_W(8), .ADDR_W(8), .STORE_CYCLES(100), .RECALL_ON_RESET(1'b0)) dut_b (
        .clk(clk), .rst(rst[1]), .we(we[1]), .addr(addr[1]), .din(din[1]), .dout(dout[1]),
        .store(store[1]), .recall(recall[1]), .busy(busy[1]),
        .host_addr(host_addr[1]), .host_we(host_we[1]), .host_din(host_din[1]), .host_dout(host_dout[1])
    );

    task automatic cpu_wr(input int u, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        we[u] = 1'b1; addr[u] = a; din[u] = d;
        @(negedge clk);
        we[u] = 1'b0;
    endtask

    task automatic cpu_rd(input int u, input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        we[u] = 1'b0; addr[u] = a;
        @(negedge clk);
        d = dout[u];
    endtask

    task automatic host_wr(input int u, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we[u] = 1'b1; host_addr[u] = a; host_din[u] = d;
        @(negedge clk);
        host_we[u] = 1'b0;
    endtask

    task automatic host_rd(input int u, input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        host_addr[u] = a;
        @(negedge clk);
        d = host_dout[u];
    endtask

    // which: 0 = rst, 1 = store, 2 = recall, 3 = store and recall together
    task automatic pulse(input int u, input int which);
        @(negedge clk);
        if (which == 0) rst[u] = 1'b1;
        if (which == 1 || which == 3) store[u] = 1'b1;
        if (which == 2 || which == 3) recall[u] = 1'b1;
        @(negedge clk);
        rst[u] = 1'b0; store[u] = 1'b0; recall[u] = 1'b0;
    endtask

    // Counts the negedges on which busy is high, starting now.
    task automatic count_busy(input int u, output int n);
        n = 0;
        while (busy[u] && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; we[u] = 1'b0; store[u] = 1'b0; recall[u] = 1'b0; host_we[u] = 1'b0;
            addr[u] = 8'h00; din[u] = 8'h00; host_addr[u] = 8'h00; host_din[u] = 8'h00;
        end
        repeat (3) @(negedge clk);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_busy_u0 got %b want 1", busy[0]); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy_u1 got %b want 0", busy[1]); end
        for (int u = 0; u < 2; u++) begin
            checks++; if (dout[u] !== 8'h00) begin errors++; $display("FAIL reset_dout u%0d got %h want 00", u, dout[u]); end
            checks++; if (host_dout[u] !== 8'h00) begin errors++; $display("FAIL reset_host_dout u%0d got %h want 00", u, host_dout[u]); end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        count_busy(0, n);
        checks++; if (n != 257) begin errors++; $display("FAIL reset_release_recall busy cycles got %0d want 257", n); end
    endtask

    task automatic test_power_on_recall;
        int n;
        logic [7:0] d, a;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            shad_m[0][i] = d;
            host_wr(0, 8'(i), d);
        end
        host_wr(0, 8'h10, 8'hA5);
        shad_m[0][8'h10] = 8'hA5;
        pulse(0, 0);
        count_busy(0, n);
        checks++; if (n != 257) begin errors++; $display("FAIL power_on_recall busy cycles got %0d want 257", n); end
        for (int i = 0; i < 256; i++) work_m[0][i] = shad_m[0][i];
        cpu_rd(0, 8'h10, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL power_on_recall dout[10] got %h want a5", d); end
        for (int k = 0; k < 12; k++) begin
            a = 8'($urandom);
            cpu_rd(0, a, d);
            checks++; if (d !== work_m[0][a]) begin errors++; $display("FAIL recall_rand addr %h got %h want %h", a, d, work_m[0][a]); end
        end
    endtask

    task automatic test_cpu_rw;
        logic [7:0] v, d, a;
        cpu_rd(0, 8'h01, v);
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 8'h7F; din[0] = 8'h3C;
        @(negedge clk);
        checks++; if (dout[0] !== v) begin errors++; $display("FAIL cpu_write_hold got %h want %h", dout[0], v); end
        we[0] = 1'b0;
        work_m[0][8'h7F] = 8'h3C;
        @(negedge clk);
        checks++; if (dout[0] !== 8'h3C) begin errors++; $display("FAIL cpu_read_7f got %h want 3c", dout[0]); end
        for (int k = 0; k < 8; k++) begin
            a = 8'($urandom); d = 8'($urandom);
            cpu_wr(0, a, d);
            work_m[0][a] = d;
        end
        for (int k = 0; k < 8; k++) begin
            a = 8'($urandom);
            cpu_rd(0, a, d);
            checks++; if (d !== work_m[0][a]) begin errors++; $display("FAIL cpu_rw_rand addr %h got %h want %h", a, d, work_m[0][a]); end
        end
    endtask

    task automatic test_store_timing;
        int n;
        logic [7:0] d, a;
        cpu_wr(0, 8'hFF, 8'h5A);
        work_m[0][8'hFF] = 8'h5A;
        pulse(0, 1);
        count_busy(0, n);
        checks++; if (n != 1000) begin errors++; $display("FAIL store_busy cycles got %0d want 1000", n); end
        for (int i = 0; i < 256; i++) shad_m[0][i] = work_m[0][i];
        host_rd(0, 8'hFF, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL store_host_ff got %h want 5a", d); end
        for (int k = 0; k < 8; k++) begin
            a = 8'($urandom);
            host_rd(0, a, d);
            checks++; if (d !== shad_m[0][a]) begin errors++; $display("FAIL store_rand addr %h got %h want %h", a, d, shad_m[0][a]); end
        end
    endtask

    task automatic test_busy_lockout;
        int n;
        int hi;
        logic [7:0] d;
        pulse(0, 1);
        repeat (10) @(negedge clk);
        cpu_wr(0, 8'h00, ~work_m[0][0]);
        pulse(0, 2);
        repeat (400) @(negedge clk);
        host_wr(0, 8'h80, ~work_m[0][8'h80]);
        count_busy(0, n);
        for (int i = 0; i < 256; i++) shad_m[0][i] = work_m[0][i];
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy[0]) hi++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL lockout_recall_dropped busy cycles got %0d want 0", hi); end
        cpu_rd(0, 8'h00, d);
        checks++; if (d !== work_m[0][0]) begin errors++; $display("FAIL lockout_cpu_write got %h want %h", d, work_m[0][0]); end
        host_rd(0, 8'h80, d);
        checks++; if (d !== shad_m[0][8'h80]) begin errors++; $display("FAIL lockout_host_write got %h want %h", d, shad_m[0][8'h80]); end
    endtask

    task automatic test_simultaneous;
        int n;
        logic [7:0] d, a;
        logic [7:0] addrs[4];
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom);
            addrs[k] = a;
            cpu_wr(0, a, ~shad_m[0][a]);
            work_m[0][a] = ~shad_m[0][a];
        end
        pulse(0, 3);
        count_busy(0, n);
        checks++; if (n != 257) begin errors++; $display("FAIL simul_recall busy cycles got %0d want 257", n); end
        for (int i = 0; i < 256; i++) work_m[0][i] = shad_m[0][i];
        for (int k = 0; k < 4; k++) begin
            host_rd(0, addrs[k], d);
            checks++; if (d !== shad_m[0][addrs[k]]) begin errors++; $display("FAIL simul_shadow addr %h got %h want %h", addrs[k], d, shad_m[0][addrs[k]]); end
            cpu_rd(0, addrs[k], d);
            checks++; if (d !== work_m[0][addrs[k]]) begin errors++; $display("FAIL simul_work addr %h got %h want %h", addrs[k], d, work_m[0][addrs[k]]); end
        end
    endtask

    task automatic test_reset_mid_store;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            shad_m[1][i] = d;
            work_m[1][i] = ~d;
            host_wr(1, 8'(i), d);
            cpu_wr(1, 8'(i), ~d);
        end
        pulse(1, 1);
        repeat (8'h40) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy[1]); end
        @(negedge clk);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL abort_busy_stays got %b want 0", busy[1]); end
        for (int i = 0; i < 8'h3F; i++) shad_m[1][i] = work_m[1][i];
        for (int i = 0; i < 256; i++) begin
            if (i == 8'h3F || i == 8'h40) continue;
            host_rd(1, 8'(i), d);
            checks++; if (d !== shad_m[1][i]) begin errors++; $display("FAIL abort_shadow addr %h got %h want %h", i, d, shad_m[1][i]); end
        end
    endtask

    task automatic test_store_clamp;
        int n;
        logic [7:0] d, a;
        pulse(1, 1);
        count_busy(1, n);
        checks++; if (n != 258) begin errors++; $display("FAIL clamp_store busy cycles got %0d want 258", n); end
        for (int i = 0; i < 256; i++) shad_m[1][i] = work_m[1][i];
        host_rd(1, 8'hFF, d);
        checks++; if (d !== shad_m[1][8'hFF]) begin errors++; $display("FAIL clamp_last_word got %h want %h", d, shad_m[1][8'hFF]); end
        host_rd(1, 8'h40, d);
        checks++; if (d !== shad_m[1][8'h40]) begin errors++; $display("FAIL clamp_word_40 got %h want %h", d, shad_m[1][8'h40]); end
        for (int k = 0; k < 6; k++) begin
            a = 8'($urandom);
            host_rd(1, a, d);
            checks++; if (d !== shad_m[1][a]) begin errors++; $display("FAIL clamp_rand addr %h got %h want %h", a, d, shad_m[1][a]); end
        end
    endtask

    initial begin
        test_reset;
        test_power_on_recall;
        test_cpu_rw;
        test_store_timing;
        test_busy_lockout;
        test_simultaneous;
        test_reset_mid_store;
        test_store_clamp;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
